// File: rtl/ones_pattern_gen.sv
// Thermometer frame generator: emits WIDTH serial bits (MSB first) holding the
// requested number of ones in the LSBs, and assembles them into a parallel word.
module ones_pattern_gen #(
  parameter int WIDTH = 16,
  parameter int CW    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CW-1:0]    count_in,
  output logic             busy,
  output logic             ser_valid,
  output logic             ser_out,
  output logic [WIDTH-1:0] DATA,
  output logic             done,
  output logic             err
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam logic [CW-1:0] WIDTH_C  = CW'(WIDTH);
  localparam logic [CW-1:0] LAST_IDX = CW'(WIDTH - 1);

  state_t             state_q, state_d;
  logic [CW-1:0]      tgt_q, tgt_d;
  logic [CW-1:0]      idx_q, idx_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   data_q, data_d;
  logic               busy_q, busy_d;
  logic               ser_valid_q, ser_valid_d;
  logic               ser_out_q, ser_out_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // Every output is a flop, so ser_out_d is computed from the index the bit
  // will be presented with (idx_d), not the current one.
  always_comb begin
    // NOTE: defaults first, so every path assigns every _d and no latch is inferred.
    state_d     = state_q;
    tgt_d       = tgt_q;
    idx_d       = idx_q;
    ovf_d       = ovf_q;
    data_d      = data_q;
    busy_d      = busy_q;
    ser_valid_d = ser_valid_q;
    ser_out_d   = ser_out_q;
    done_d      = 1'b0;
    err_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          // NOTE: blocking '=' in combinational logic, so ovf_d is usable on the next line.
          ovf_d       = (count_in > WIDTH_C);
          tgt_d       = ovf_d ? WIDTH_C : count_in;
          data_d      = '0;
          idx_d       = LAST_IDX;
          busy_d      = 1'b1;
          ser_valid_d = 1'b1;
          ser_out_d   = (LAST_IDX < tgt_d);
          state_d     = SHIFT;
        end
      end

      SHIFT: begin
        data_d = {data_q[WIDTH-2:0], ser_out_q};
        if (idx_q == '0) begin
          // Last bit consumed; idx stays at 0 rather than wrapping.
          ser_valid_d = 1'b0;
          ser_out_d   = 1'b0;
          done_d      = 1'b1;
          err_d       = ovf_q;
          state_d     = DONE;
        end else begin
          idx_d     = idx_q - CW'(1);
          ser_out_d = (idx_d < tgt_q);
        end
      end

      DONE: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end

      default: begin
        state_d     = IDLE;
        busy_d      = 1'b0;
        ser_valid_d = 1'b0;
        ser_out_d   = 1'b0;
      end
    endcase
  end

  // NOTE: sequential state uses non-blocking '<=' so all flops update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      tgt_q       <= '0;
      idx_q       <= LAST_IDX;
      ovf_q       <= 1'b0;
      data_q      <= '0;
      busy_q      <= 1'b0;
      ser_valid_q <= 1'b0;
      ser_out_q   <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      idx_q       <= idx_d;
      ovf_q       <= ovf_d;
      data_q      <= data_d;
      busy_q      <= busy_d;
      ser_valid_q <= ser_valid_d;
      ser_out_q   <= ser_out_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign busy      = busy_q;
  assign ser_valid = ser_valid_q;
  assign ser_out   = ser_out_q;
  assign DATA      = data_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_ones_pattern_gen.sv
// Self-checking bench for ones_pattern_gen: expected serial bits and frame
// results are queued when a start is driven and popped as the DUT emits them.
module tb_ones_pattern_gen;

  localparam int WIDTH = 16;
  localparam int CW    = 5;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             start;
  logic [CW-1:0]    count_in;
  logic             busy;
  logic             ser_valid;
  logic             ser_out;
  logic [WIDTH-1:0] DATA;
  logic             done;
  logic             err;

  typedef struct {
    logic [WIDTH-1:0] data;
    logic             err;
    int               tgt;
  } res_t;

  bit   exp_bits[$];
  res_t res_q[$];
  int   total = 0;
  int   bad   = 0;

  ones_pattern_gen #(.WIDTH(WIDTH), .CW(CW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .count_in  (count_in),
    .busy      (busy),
    .ser_valid (ser_valid),
    .ser_out   (ser_out),
    .DATA      (DATA),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Reference model: frame bit for index i is (i < min(c, WIDTH)).
  task automatic push_frame(input int c);
    res_t r;
    logic [WIDTH:0] full;
    r.tgt = (c > WIDTH) ? WIDTH : c;
    for (int i = WIDTH - 1; i >= 0; i--) exp_bits.push_back(i < r.tgt);
    full   = ({{WIDTH{1'b0}}, 1'b1} << r.tgt) - 1;
    r.data = full[WIDTH-1:0];
    r.err  = (c > WIDTH);
    res_q.push_back(r);
  endtask

  // Caller is positioned away from the rising edge; start is accepted at the next edge.
  task automatic run_frame(input int c, input bit hold, input string name);
    bit   b;
    res_t r;
    push_frame(c);
    start    = 1'b1;
    count_in = CW'(c);
    @(posedge clk);
    #1;
    if (!hold) start = 1'b0;
    for (int n = 0; n < WIDTH; n++) begin
      @(negedge clk);
      b = exp_bits.pop_front();
      total++;
      if ({busy, ser_valid, ser_out, done} !== {1'b1, 1'b1, b, 1'b0}) begin
        bad++;
        $display("FAIL %s bit%0d {busy,valid,ser_out,done}: got %b want %b",
                 name, n, {busy, ser_valid, ser_out, done}, {1'b1, 1'b1, b, 1'b0});
      end
    end
    @(negedge clk);
    r = res_q.pop_front();
    total++;
    if ({busy, ser_valid, ser_out, done, err} !== {1'b1, 1'b0, 1'b0, 1'b1, r.err}) begin
      bad++;
      $display("FAIL %s done_cycle {busy,valid,ser_out,done,err}: got %b want %b",
               name, {busy, ser_valid, ser_out, done, err}, {1'b1, 1'b0, 1'b0, 1'b1, r.err});
    end
    total++;
    if (DATA !== r.data) begin
      bad++;
      $display("FAIL %s DATA: got %h want %h", name, DATA, r.data);
    end
    total++;
    if ($countones(DATA) != r.tgt) begin
      bad++;
      $display("FAIL %s popcount: got %0d want %0d", name, $countones(DATA), r.tgt);
    end
    @(negedge clk);
    total++;
    if ({busy, ser_valid, ser_out, done, err} !== 5'b0 || DATA !== r.data) begin
      bad++;
      $display("FAIL %s idle_after {busy,valid,ser_out,done,err}/DATA: got %b/%h want 00000/%h",
               name, {busy, ser_valid, ser_out, done, err}, DATA, r.data);
    end
  endtask

  task automatic test_reset();
    rst_n    = 1'b0;
    start    = 1'b0;
    count_in = '0;
    #2;
    total++;
    if ({busy, ser_valid, ser_out, done, err} !== 5'b0 || DATA !== '0) begin
      bad++;
      $display("FAIL reset_state: got %b/%h want 00000/0000",
               {busy, ser_valid, ser_out, done, err}, DATA);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_full();     run_frame(16, 1'b0, "full16");  endtask
  task automatic test_zero();     run_frame(0,  1'b0, "zero");    endtask
  task automatic test_five();     run_frame(5,  1'b0, "five");    endtask
  task automatic test_overflow(); run_frame(31, 1'b0, "ovf31");   endtask

  // Start held high: one frame only, next accept exactly at edge k+WIDTH+2.
  task automatic test_back_to_back();
    run_frame(3, 1'b1, "held_a");
    run_frame(3, 1'b0, "held_b");
  endtask

  task automatic test_abort();
    start    = 1'b1;
    count_in = CW'(5);
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    total++;
    if ({busy, ser_valid, ser_out, done, err} !== 5'b0 || DATA !== '0) begin
      bad++;
      $display("FAIL abort_reset: got %b/%h want 00000/0000",
               {busy, ser_valid, ser_out, done, err}, DATA);
    end
    for (int n = 0; n < 3; n++) begin
      @(negedge clk);
      total++;
      if (done !== 1'b0 || busy !== 1'b0) begin
        bad++;
        $display("FAIL abort_no_done cyc%0d: got done=%b busy=%b want 0 0", n, done, busy);
      end
    end
    rst_n = 1'b1;
    run_frame(9, 1'b0, "after_abort");
  endtask

  task automatic test_random();
    for (int n = 0; n < 4; n++) run_frame(int'($urandom_range(0, 31)), 1'b0, "random");
  endtask

  initial begin
    test_reset();
    test_full();
    test_zero();
    test_five();
    test_overflow();
    test_back_to_back();
    test_abort();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
